// File: rtl/two_seven_segment_scanner_if.sv
// Display-scanner bundle: load/data/blank into the scanner, segment/digit drives and scan tick out.
// Latency: n/a (signal grouping only).
// Backpressure: none; the scanner accepts a load on any cycle.
interface two_seven_segment_scanner_if #(
  parameter int NUM_DIGITS = 2
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   data_in;
  logic                      blank;
  logic [6:0]                seg_n;
  logic [NUM_DIGITS-1:0]     dig_n;
  logic                      scan_tick;

  // Producer of display data (and consumer of the drive outputs)
  modport master (
    output load, data_in, blank,
    input  seg_n, dig_n, scan_tick
  );

  // The scanner itself
  modport slave (
    input  load, data_in, blank,
    output seg_n, dig_n, scan_tick
  );
endinterface

// File: rtl/two_seven_segment_scanner.sv
// Multiplexed hex display scanner: one digit enabled per SCAN_DIV-cycle slot, hex-decoded segments.
// Latency: seg_n/dig_n registered, 1 cycle after index/value/blank; scan_tick is same-cycle.
// Backpressure: none; optional LEADING_ZERO_BLANK_EN macro suppresses segments of leading zero digits.
module two_seven_segment_scanner #(
  parameter int NUM_DIGITS = 2,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                            clk,
  input  logic                            rst,
  two_seven_segment_scanner_if.slave      bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [VAL_W-1:0]      value_q, value_d;
  logic [PRE_W-1:0]      presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [6:0]            seg_n_q, seg_n_d;
  logic [NUM_DIGITS-1:0] dig_n_q, dig_n_d;
  logic                  tick;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [3:0]            cur_nib;
  logic                  cur_lz;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble
  function automatic logic [6:0] hex_to_seg_n(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Tick is decoded straight from the prescaler so it lands in the cycle the count hits its last value
  assign tick = (presc_q == PRE_LAST);

  // Per-digit flag: digit is a suppressible leading zero (never digit 0)
  always_comb begin
    lz_mask = '0;
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = 1; i < NUM_DIGITS; i++) begin
      lz_mask[i] = ((value_q >> (4 * i)) == '0);
    end
`endif
  end

  // Pick out the nibble and leading-zero flag of the digit currently being scanned
  always_comb begin
    cur_nib = 4'h0;
    cur_lz  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib = value_q[4*i +: 4];
        cur_lz  = lz_mask[i];
      end
    end
  end

  // Next state: value latch, free-running prescaler, digit index, registered drive outputs
  always_comb begin
    value_d = bus.load ? bus.data_in : value_q;
    presc_d = tick ? '0 : presc_q + PRE_W'(1);
    idx_d   = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    dig_n_d = '1;
    seg_n_d = 7'h7F;
    if (!bus.blank) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        dig_n_d[i] = (idx_q != IDX_W'(i));
      end
      seg_n_d = cur_lz ? 7'h7F : hex_to_seg_n(cur_nib);
    end
  end

  // State registers; reset clears counters and drives the display dark immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      seg_n_q <= 7'h7F;
      dig_n_q <= '1;
    end else begin
      value_q <= value_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      seg_n_q <= seg_n_d;
      dig_n_q <= dig_n_d;
    end
  end

  assign bus.seg_n     = seg_n_q;
  assign bus.dig_n     = dig_n_q;
  assign bus.scan_tick = tick;

endmodule

// File: tb/tb_two_seven_segment_scanner.sv
// Self-checking bench for two_seven_segment_scanner (4 digits, 4-cycle scan slot).
// Reference model: scan position derived arithmetically from edges since reset release.
// Inputs driven 1 time unit after the rising edge; outputs sampled there too.
module tb_two_seven_segment_scanner;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic clk;
  logic rst;
  int   total;
  int   bad;

  two_seven_segment_scanner_if #(.NUM_DIGITS(ND)) bus ();

  two_seven_segment_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state
  int          m_n;      // rising edges since reset release
  logic [15:0] m_val;
  logic [6:0]  exp_seg;
  logic [3:0]  exp_dig;
  logic        exp_tick;

  function automatic logic [6:0] seg_ref(input logic [15:0] v, input int idx, input logic blk);
    logic [3:0] nib;
    nib = v[4*idx +: 4];
    if (blk) return 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && v < (16'h1 << (4 * idx))) return 7'h7F;
`endif
    return HEX[nib];
  endfunction

  // One clock: predict registered outputs from pre-edge state, update model, then sample point
  task automatic advance();
    logic [6:0] s;
    logic [3:0] d;
    int idx;
    s = 7'h7F;
    d = 4'hF;
    if (rst) begin
      m_n   = 0;
      m_val = '0;
    end else begin
      idx = (m_n / SD) % ND;
      if (!bus.blank) d[idx] = 1'b0;
      s = seg_ref(m_val, idx, bus.blank);
      if (bus.load) m_val = bus.data_in;
      m_n++;
    end
    @(posedge clk);
    #1;
    exp_seg  = s;
    exp_dig  = d;
    exp_tick = !rst && ((m_n % SD) == SD - 1);
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (bus.seg_n !== 7'h7F) begin bad++; $display("FAIL reset_seg: got %h want 7f", bus.seg_n); end
    total++;
    if (bus.dig_n !== 4'hF) begin bad++; $display("FAIL reset_dig: got %h want f", bus.dig_n); end
    total++;
    if (bus.scan_tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", bus.scan_tick); end
    advance();
    advance();
    rst = 1'b0;
    total++;
    if (bus.scan_tick !== 1'b0) begin bad++; $display("FAIL release_tick: got %b want 0", bus.scan_tick); end
  endtask

  task automatic test_scan_tick();
    int first;
    first = -1;
    for (int c = 0; c < 16; c++) begin
      advance();
      if (bus.scan_tick === 1'b1 && first < 0) first = m_n;
      total++;
      if (bus.scan_tick !== exp_tick) begin
        bad++; $display("FAIL scan_tick: edge %0d got %b want %b", m_n, bus.scan_tick, exp_tick);
      end
      total++;
      if (bus.seg_n !== exp_seg || bus.dig_n !== exp_dig) begin
        bad++; $display("FAIL tick_outputs: got seg %h dig %h want seg %h dig %h", bus.seg_n, bus.dig_n, exp_seg, exp_dig);
      end
    end
    total++;
    if (first != SD - 1) begin bad++; $display("FAIL first_tick: got edge %0d want %0d", first, SD - 1); end
  endtask

  task automatic test_pattern();
    logic [6:0] want;
    bus.load = 1'b1; bus.data_in = 16'h12AF;
    advance();
    bus.load = 1'b0;
    for (int c = 0; c < 20; c++) begin
      advance();
      total++;
      if (bus.seg_n !== exp_seg || bus.dig_n !== exp_dig) begin
        bad++; $display("FAIL pattern: got seg %h dig %h want seg %h dig %h", bus.seg_n, bus.dig_n, exp_seg, exp_dig);
      end
      case (bus.dig_n)
        4'hE: want = 7'h0E;
        4'hD: want = 7'h08;
        4'hB: want = 7'h24;
        4'h7: want = 7'h79;
        default: want = 7'h7F;
      endcase
      total++;
      if (bus.seg_n !== want) begin bad++; $display("FAIL pattern_decode: dig %h got seg %h want %h", bus.dig_n, bus.seg_n, want); end
    end
  endtask

  task automatic test_leading_zero();
    logic [6:0] want;
    bus.load = 1'b1; bus.data_in = 16'h0007;
    advance();
    bus.load = 1'b0;
    advance();
    for (int c = 0; c < 16; c++) begin
      advance();
      total++;
      if (bus.seg_n !== exp_seg || bus.dig_n !== exp_dig) begin
        bad++; $display("FAIL lz_model: got seg %h dig %h want seg %h dig %h", bus.seg_n, bus.dig_n, exp_seg, exp_dig);
      end
`ifdef LEADING_ZERO_BLANK_EN
      want = (bus.dig_n == 4'hE) ? 7'h78 : 7'h7F;
`else
      want = (bus.dig_n == 4'hE) ? 7'h78 : 7'h40;
`endif
      total++;
      if (bus.seg_n !== want) begin bad++; $display("FAIL lz_digit: dig %h got seg %h want %h", bus.dig_n, bus.seg_n, want); end
    end
  endtask

  task automatic test_blank();
    bus.load = 1'b1; bus.data_in = 16'h9C5B;
    advance();
    bus.load = 1'b0;
    advance();
    bus.blank = 1'b1;
    for (int c = 0; c < 10; c++) begin
      advance();
      total++;
      if (bus.dig_n !== 4'hF || bus.seg_n !== 7'h7F) begin
        bad++; $display("FAIL blank_on: got seg %h dig %h want seg 7f dig f", bus.seg_n, bus.dig_n);
      end
    end
    bus.blank = 1'b0;
    for (int c = 0; c < 12; c++) begin
      advance();
      total++;
      if (bus.seg_n !== exp_seg || bus.dig_n !== exp_dig || bus.scan_tick !== exp_tick) begin
        bad++; $display("FAIL blank_resume: got seg %h dig %h tick %b want seg %h dig %h tick %b",
                        bus.seg_n, bus.dig_n, bus.scan_tick, exp_seg, exp_dig, exp_tick);
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    bus.load = 1'b1; bus.data_in = 16'h4321;
    advance();
    bus.load = 1'b0;
    while ((m_n % (SD * ND)) != 2 * SD + 1 && guard < 40) begin
      advance();
      guard++;
    end
    total++;
    if (bus.dig_n !== 4'hB) begin bad++; $display("FAIL pre_reset_dig: got %h want b", bus.dig_n); end
    rst = 1'b1;
    #1;
    total++;
    if (bus.seg_n !== 7'h7F || bus.dig_n !== 4'hF || bus.scan_tick !== 1'b0) begin
      bad++; $display("FAIL async_reset: got seg %h dig %h tick %b want 7f f 0", bus.seg_n, bus.dig_n, bus.scan_tick);
    end
    advance();
    rst = 1'b0;
    for (int c = 0; c < 9; c++) begin
      advance();
      total++;
      if (bus.seg_n !== exp_seg || bus.dig_n !== exp_dig || bus.scan_tick !== exp_tick) begin
        bad++; $display("FAIL reset_resume: got seg %h dig %h tick %b want seg %h dig %h tick %b",
                        bus.seg_n, bus.dig_n, bus.scan_tick, exp_seg, exp_dig, exp_tick);
      end
      if (c < SD) begin
        total++;
        if (bus.dig_n !== 4'hE || bus.seg_n !== 7'h40) begin
          bad++; $display("FAIL reset_slot0: cycle %0d got seg %h dig %h want 40 e", c, bus.seg_n, bus.dig_n);
        end
      end
    end
  endtask

  task automatic test_load_on_tick();
    int guard;
    guard = 0;
    bus.load = 1'b1; bus.data_in = 16'h0000;
    advance();
    bus.load = 1'b0;
    while ((m_n % SD) != SD - 1 && guard < 8) begin
      advance();
      guard++;
    end
    total++;
    if (bus.scan_tick !== 1'b1) begin bad++; $display("FAIL tick_before_load: got %b want 1", bus.scan_tick); end
    bus.load = 1'b1; bus.data_in = 16'h3333;
    advance();
    bus.load = 1'b0;
    advance();
    total++;
    if (bus.seg_n !== 7'h30 || bus.dig_n !== exp_dig) begin
      bad++; $display("FAIL load_on_tick: got seg %h dig %h want seg 30 dig %h", bus.seg_n, bus.dig_n, exp_dig);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.load    = ($urandom_range(0, 5) == 0);
      bus.data_in = 16'($urandom);
      if ($urandom_range(0, 1) == 0) bus.data_in = bus.data_in >> (4 * $urandom_range(0, 3));
      bus.blank   = ($urandom_range(0, 9) == 0);
      advance();
      total++;
      if (bus.seg_n !== exp_seg || bus.dig_n !== exp_dig || bus.scan_tick !== exp_tick) begin
        bad++; $display("FAIL random: cycle %0d got seg %h dig %h tick %b want seg %h dig %h tick %b",
                        c, bus.seg_n, bus.dig_n, bus.scan_tick, exp_seg, exp_dig, exp_tick);
      end
    end
    bus.load  = 1'b0;
    bus.blank = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    total       = 0;
    bad         = 0;
    m_n         = 0;
    m_val       = '0;
    exp_seg     = 7'h7F;
    exp_dig     = 4'hF;
    exp_tick    = 1'b0;
    rst         = 1'b1;
    bus.load    = 1'b0;
    bus.blank   = 1'b0;
    bus.data_in = '0;
    test_reset();
    test_scan_tick();
    test_pattern();
    test_leading_zero();
    test_blank();
    test_reset_mid();
    test_load_on_tick();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
